// File: rtl/wb_queue_if.sv
// Write-back queue bus: request side, register-file write port, read-forward lookup and status.
interface wb_queue_if #(parameter int DEPTH = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_rd;
  logic [31:0]              in_data;
  logic                     drain_stall;
  logic [31:0]              C;
  logic [3:0]               rc;
  logic                     le;
  logic [3:0]               ra;
  logic [3:0]               rb;
  logic                     fwd_a_hit;
  logic                     fwd_b_hit;
  logic [31:0]              fwd_a;
  logic [31:0]              fwd_b;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  modport master (
    output in_valid, in_rd, in_data, drain_stall, ra, rb,
    input  in_ready, C, rc, le, fwd_a_hit, fwd_b_hit, fwd_a, fwd_b, count, empty
  );

  modport slave (
    input  in_valid, in_rd, in_data, drain_stall, ra, rb,
    output in_ready, C, rc, le, fwd_a_hit, fwd_b_hit, fwd_a, fwd_b, count, empty
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back FIFO feeding the 16x32 register file write port (C/rc/le, le active-low).
// Optional read forwarding of the youngest pending value is enabled by defining WBQ_FWD_EN.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic      clk,
  input logic      clr,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          full;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign push  = bus.in_valid && !full && !clr;
  assign pop   = (cnt != '0) && !bus.drain_stall && !clr;

  // Ready is forced high during reset even if the queue was full; the push is still masked.
  assign bus.in_ready = clr || !full;
  assign bus.count    = cnt;
  assign bus.empty    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= bus.in_rd;
      data_mem[tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      bus.le <= 1'b1;
      bus.C  <= '0;
      bus.rc <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        bus.C  <= data_mem[head];
        bus.rc <= rd_mem[head];
        bus.le <= 1'b0;
        head   <= head + 1'b1;
      end else begin
        bus.le <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef WBQ_FWD_EN
  // Scan oldest to youngest so later matches override; the output stage is lowest priority.
  always_comb begin
    bus.fwd_a_hit = 1'b0;
    bus.fwd_b_hit = 1'b0;
    bus.fwd_a     = '0;
    bus.fwd_b     = '0;
    if (!bus.le && bus.rc == bus.ra) begin
      bus.fwd_a_hit = 1'b1;
      bus.fwd_a     = bus.C;
    end
    if (!bus.le && bus.rc == bus.rb) begin
      bus.fwd_b_hit = 1'b1;
      bus.fwd_b     = bus.C;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if (rd_mem[head + PW'(i)] == bus.ra) begin
          bus.fwd_a_hit = 1'b1;
          bus.fwd_a     = data_mem[head + PW'(i)];
        end
        if (rd_mem[head + PW'(i)] == bus.rb) begin
          bus.fwd_b_hit = 1'b1;
          bus.fwd_b     = data_mem[head + PW'(i)];
        end
      end
    end
  end
`else
  logic unused_read_addr;

  assign unused_read_addr = ^{bus.ra, bus.rb};
  assign bus.fwd_a_hit    = 1'b0;
  assign bus.fwd_b_hit    = 1'b0;
  assign bus.fwd_a        = '0;
  assign bus.fwd_b        = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH = 4); forwarding expectations follow WBQ_FWD_EN.
module tb_wb_queue;
`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  wb_queue_if #(.DEPTH(4)) bus ();

  wb_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] rd, input logic [31:0] data,
                                input logic stall);
    bus.in_valid    = valid;
    bus.in_rd       = rd;
    bus.in_data     = data;
    bus.drain_stall = stall;
  endtask

  initial begin
    apply_stimulus(1'b1, 4'd2, 32'h77, 1'b0);
    bus.ra = 4'd0;
    bus.rb = 4'd0;
    step();
    check_output("ready_in_clr", 32'(bus.in_ready), 32'd1);
    step();
    check_output("rst_le", 32'(bus.le), 32'd1);
    check_output("rst_c", bus.C, 32'h0);
    check_output("rst_rc", 32'(bus.rc), 32'd0);
    check_output("rst_count", 32'(bus.count), 32'd0);
    check_output("rst_empty", 32'(bus.empty), 32'd1);
    check_output("rst_hit_a", 32'(bus.fwd_a_hit), 32'd0);

    // Single write
    clr = 1'b0;
    apply_stimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    bus.ra = 4'd5;
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b0);
    check_output("sw_count1", 32'(bus.count), 32'd1);
    check_output("sw_le_edge1", 32'(bus.le), 32'd1);
    check_output("sw_fwd_hit_q", 32'(bus.fwd_a_hit), FWD ? 32'd1 : 32'd0);
    check_output("sw_fwd_q", bus.fwd_a, FWD ? 32'hDEADBEEF : 32'h0);
    step();
    check_output("sw_le", 32'(bus.le), 32'd0);
    check_output("sw_rc", 32'(bus.rc), 32'd5);
    check_output("sw_c", bus.C, 32'hDEADBEEF);
    check_output("sw_empty", 32'(bus.empty), 32'd1);
    check_output("sw_fwd_out", bus.fwd_a, FWD ? 32'hDEADBEEF : 32'h0);
    step();
    check_output("sw_le_after", 32'(bus.le), 32'd1);
    check_output("sw_c_hold", bus.C, 32'hDEADBEEF);
    check_output("sw_hit_gone", 32'(bus.fwd_a_hit), 32'd0);

    // Fill with stall, fifth push refused, then drain in order
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b1, 4'(k), 32'(k * 'h11), 1'b1);
      check_output("fill_ready", 32'(bus.in_ready), (k <= 4) ? 32'd1 : 32'd0);
      step();
    end
    check_output("fill_count", 32'(bus.count), 32'd4);
    check_output("fill_le", 32'(bus.le), 32'd1);
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_output("drain_le", 32'(bus.le), 32'd0);
      check_output("drain_rc", 32'(bus.rc), 32'(k));
      check_output("drain_c", bus.C, 32'(k * 'h11));
    end
    step();
    check_output("drain_le_end", 32'(bus.le), 32'd1);
    check_output("drain_count", 32'(bus.count), 32'd0);

    // Wrap-around: one entry primed, then push and pop on each edge
    apply_stimulus(1'b1, 4'd0, 32'h100, 1'b0);
    step();
    for (int j = 0; j < 10; j++) begin
      apply_stimulus(1'b1, 4'(j + 1), 32'h200 + 32'(j), 1'b0);
      step();
      check_output("wrap_count", 32'(bus.count), 32'd1);
      check_output("wrap_le", 32'(bus.le), 32'd0);
      check_output("wrap_rc", 32'(bus.rc), 32'(j));
      check_output("wrap_c", bus.C, (j == 0) ? 32'h100 : 32'h200 + 32'(j - 1));
    end
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b0);
    step();
    check_output("wrap_last_rc", 32'(bus.rc), 32'd10);
    check_output("wrap_last_c", bus.C, 32'h209);
    check_output("wrap_empty", 32'(bus.empty), 32'd1);
    step();

    // Forwarding priority with duplicate destinations
    apply_stimulus(1'b1, 4'd3, 32'hA, 1'b1);
    step();
    apply_stimulus(1'b1, 4'd3, 32'hB, 1'b1);
    step();
    apply_stimulus(1'b1, 4'd7, 32'hC, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b1);
    bus.ra = 4'd3;
    bus.rb = 4'd7;
    check_output("fwd_a_hit", 32'(bus.fwd_a_hit), FWD ? 32'd1 : 32'd0);
    check_output("fwd_a", bus.fwd_a, FWD ? 32'hB : 32'h0);
    check_output("fwd_b_hit", 32'(bus.fwd_b_hit), FWD ? 32'd1 : 32'd0);
    check_output("fwd_b", bus.fwd_b, FWD ? 32'hC : 32'h0);
    bus.drain_stall = 1'b0;
    step();
    check_output("fwd_d1_a", bus.fwd_a, FWD ? 32'hB : 32'h0);
    step();
    check_output("fwd_d2_a", bus.fwd_a, FWD ? 32'hB : 32'h0);
    check_output("fwd_d2_rc", 32'(bus.rc), 32'd3);
    step();
    check_output("fwd_d3_a_hit", 32'(bus.fwd_a_hit), 32'd0);
    check_output("fwd_d3_b", bus.fwd_b, FWD ? 32'hC : 32'h0);
    step();
    check_output("fwd_end_a_hit", 32'(bus.fwd_a_hit), 32'd0);
    check_output("fwd_end_b_hit", 32'(bus.fwd_b_hit), 32'd0);

    // Reset in the middle of a drain
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 4'(9 + k), 32'h900 + 32'(k), 1'b1);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b0);
    step();
    check_output("mid_le", 32'(bus.le), 32'd0);
    check_output("mid_count", 32'(bus.count), 32'd2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_output("mid_rst_le", 32'(bus.le), 32'd1);
    check_output("mid_rst_count", 32'(bus.count), 32'd0);
    check_output("mid_rst_c", bus.C, 32'h0);
    check_output("mid_rst_rc", 32'(bus.rc), 32'd0);
    step();
    check_output("mid_post_le", 32'(bus.le), 32'd1);
    check_output("mid_post_count", 32'(bus.count), 32'd0);

    // Full queue with simultaneous pop: push refused, accepted next edge
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 4'(12 + k), 32'hC0 + 32'(k), 1'b1);
      step();
    end
    check_output("full_ready", 32'(bus.in_ready), 32'd0);
    apply_stimulus(1'b1, 4'd1, 32'h1234, 1'b0);
    step();
    check_output("full_pop_count", 32'(bus.count), 32'd3);
    check_output("full_pop_rc", 32'(bus.rc), 32'd12);
    check_output("full_pop_ready", 32'(bus.in_ready), 32'd1);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b0);
    check_output("full_next_count", 32'(bus.count), 32'd3);
    check_output("full_next_rc", 32'(bus.rc), 32'd13);
    step();
    step();
    step();
    check_output("full_last_rc", 32'(bus.rc), 32'd1);
    check_output("full_last_c", bus.C, 32'h1234);
    step();
    check_output("full_end_le", 32'(bus.le), 32'd1);
    check_output("full_end_empty", 32'(bus.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue placed directly upstream of the 16×32 register file. It accepts write-back requests (destination register plus 32-bit result) from the execute/memory side and buffers them in a DEPTH-entry FIFO. It drains one request per cycle onto the register file write port (`C`, `rc`, active-low `le`). Optionally, it forwards the youngest pending value for the two read addresses, so reads issued while writes are still queued return current data.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; must be a power of two in the range 2–8.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `clr`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  a write-back request is present.
- `in_ready`  out  1  queue can accept a request; `in_ready` = !full.
- `in_rd`  in  4  destination register number.
- `in_data`  in  32  value to write.
- `drain_stall`  in  1  while high, no entry is popped.
- `C`  out  32  write data to the register file.
- `rc`  out  4  write address to the register file.
- `le`  out  1  register file load enable, active-low.
- `ra`, `rb`  in  4 each  read addresses presented to the register file.
- `fwd_a_hit`, `fwd_b_hit`  out  1 each  a pending write targets `ra` / `rb`.
- `fwd_a`, `fwd_b`  out  32 each  youngest pending value for `ra` / `rb`.
- `count`  out  clog2(DEPTH)+1  number of occupied FIFO entries; the output stage is not counted.
- `empty`  out  1  `count` == 0.

## Operation
- **Push:** occurs at an edge where `in_valid` && `in_ready` && !`clr`. The pair (`in_rd`, `in_data`) is written at the tail, and the tail pointer wraps modulo DEPTH.
- **Pop:** occurs at an edge where !`empty` && !`drain_stall` && !`clr`.
  - The head entry loads the output stage: `C` ← data, `rc` ← rd, `le` ← 0.
  - The head pointer wraps modulo DEPTH.
- **No pop:** at an edge with no pop, `le` ← 1. `C` and `rc` hold their previous values.
- **Push and pop in the same edge:** both take effect and `count` is unchanged.
- **Full:** `in_ready` = 0. A push is refused even if a pop happens on the same edge; no same-cycle slot reuse.
- **Empty:** no pop occurs, and `le` stays at 1. A request pushed into an empty queue is not bypassed straight to the output stage.
- **Register 0:** no special case. r0 is written like any other register.
- **Forwarding search set:**
  - every valid FIFO entry, plus
  - the output stage when `le` = 0, because the register file has not captured it yet.
- **Forwarding result:**
  - Candidates are entries whose rd equals `ra` (or `rb`).
  - Priority is youngest first: tail−1 back to the head, then the output stage.
  - On a hit, `fwd_x_hit` = 1 and `fwd_x` = the matching data.
  - With no match, hit = 0 and data = 0.
  - The forwarding logic is purely combinational from the current state and `ra`/`rb`.
- **Duplicate destinations:** multiple pending writes to the same register are kept in order. Each drains separately, and only the youngest is forwarded.

## Timing
- **Reset state:** while `clr` is high at an edge, all of the following are set:
  - head = tail = 0, `count` = 0, `empty` = 1
  - `le` = 1, `C` = 0, `rc` = 0
  - `fwd_*_hit` = 0, `fwd_*` = 0
  - FIFO contents are don't-care.
- **`in_ready` during reset:** `in_ready` = 1 while `clr` is high, but a push is ignored on any edge where `clr` is high.
- **Reset mid-operation:** all queued and in-flight writes are discarded. `le` returns to 1 at that edge, so no register-file write occurs in the following cycle.
- **Latency, accept to write:**
  - push at edge N into an empty, unstalled queue
  - pop at edge N+1, with `le` low during cycle N+1..N+2
  - register file captures at edge N+2
- **Throughput:** one write per cycle sustained when `in_valid` is continuous and `drain_stall` is low. `le` stays low continuously in that case.
- **`drain_stall`:** is sampled at the edge. Raising it forces `le` = 1 from the next cycle, and the queue fills at up to one entry per cycle.
- **Forwarding visibility:** valid from the cycle after a push until the cycle after the matching pop. After that point the register file holds the value.

## Configuration
- **`WBQ_FWD_EN` defined:** the forwarding comparators and priority mux are compiled in, as described above.
- **`WBQ_FWD_EN` undefined:** `fwd_a_hit` = `fwd_b_hit` = 0 and `fwd_a` = `fwd_b` = 0 constantly, with no compare logic. Queue behaviour is otherwise identical.

## Test plan
- **Single write:** reset, then push (rd = 5, data = 0xDEADBEEF) at edge 1.
  - `le` = 0, `rc` = 5, `C` = 0xDEADBEEF during cycle 2 only.
  - `empty` = 1 after edge 2.
- **Fill and drain (DEPTH = 4):** `drain_stall` = 1, push rd = 1..5 with data 0x11..0x55.
  - The first four are accepted, then `in_ready` = 0 and `count` = 4.
  - Release the stall: `le` is low for 4 consecutive cycles with `rc` = 1, 2, 3, 4 in order.
- **Wrap-around:** 10 pushes, with a push and a pop on every edge.
  - `count` stays at 1.
  - Outputs appear in push order with no loss across the pointer wrap.
- **Forwarding:** stalled, with pushes (3, 0xA), (3, 0xB), (7, 0xC); `ra` = 3, `rb` = 7.
  - `fwd_a` = 0xB, `fwd_b` = 0xC, both hits = 1.
  - After the full drain plus one cycle, both hits = 0.
  - Without `WBQ_FWD_EN`, hits = 0 throughout.
- **Reset mid-drain:** 3 entries queued, `le` = 0, then `clr` is pulsed for one edge.
  - Next cycle: `le` = 1, `count` = 0, `C` = 0, `rc` = 0.
  - No further writes.
- **Full with simultaneous pop:** full queue, `in_valid` = 1 and a pop on the same edge.
  - The push is refused and `count` becomes DEPTH−1.
  - The push is accepted on the next edge.
